// File: rtl/mbist_pkg.sv
// March C- sequencer definitions: FSM states, march operations and the
// per-element direction and operation tables.
package mbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  typedef enum logic [1:0] {W0, W1, R0, R1} march_op_t;

  localparam int unsigned NUM_ELEM = 6;
  localparam int unsigned ELEM_IW  = 3;
  typedef logic [ELEM_IW-1:0] elem_idx_t;

  // Bit e set: element e walks addresses downward (M3..M5).
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN    = 6'b111000;
  // Bit e set: element e has two operations per address (M1..M4).
  localparam logic [NUM_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;
  // First and second operation of each element (second unused for 1-op elements).
  localparam march_op_t ELEM_OP0 [NUM_ELEM] = '{W0, R0, R1, R0, R1, R0};
  localparam march_op_t ELEM_OP1 [NUM_ELEM] = '{W0, W1, W0, W1, W0, W0};

  function automatic logic elem_down(input elem_idx_t e);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_ELEM; i++)
      if (e == ELEM_IW'(i)) r = ELEM_DOWN[i];
    return r;
  endfunction

  function automatic logic elem_two_ops(input elem_idx_t e);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_ELEM; i++)
      if (e == ELEM_IW'(i)) r = ELEM_TWO_OPS[i];
    return r;
  endfunction

  function automatic march_op_t elem_op(input elem_idx_t e, input logic idx);
    march_op_t r;
    r = R0;
    for (int i = 0; i < NUM_ELEM; i++)
      if (e == ELEM_IW'(i)) r = idx ? ELEM_OP1[i] : ELEM_OP0[i];
    return r;
  endfunction

endpackage

// File: rtl/mbist_controller_if.sv
// BIST-side memory port bundle.
// master: the controller (drives strobes, address, data, results).
// slave : the requester/memory side (drives start and read data).
interface mbist_controller_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  start;
  logic                  NbarT;
  logic [ADDR_WIDTH-1:0] bist_addr;
  logic [DATA_WIDTH-1:0] bist_wdata;
  logic                  bist_we;
  logic                  bist_re;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;

  modport master (
    input  start, mem_rdata,
    output NbarT, bist_addr, bist_wdata, bist_we, bist_re, done, fail, fail_addr
  );

  modport slave (
    output start, mem_rdata,
    input  NbarT, bist_addr, bist_wdata, bist_we, bist_re, done, fail, fail_addr
  );
endinterface

// File: rtl/mbist_controller_addr_gen.sv
// Up/down address counter with load and a last-address flag.
// i_load/i_load_val : load a start address (wins over i_step)
// i_step/i_down     : advance one address in the given direction
// o_addr            : registered address
// o_last_c          : address is the final one for the current direction
module addr_gen #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_val,
  input  logic                  i_step,
  input  logic                  i_down,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last_c
);
  logic [ADDR_WIDTH-1:0] r_addr;

  // Address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_addr <= '0;
    else if (i_load) r_addr <= i_load_val;
    else if (i_step) r_addr <= i_down ? r_addr - ADDR_WIDTH'(1) : r_addr + ADDR_WIDTH'(1);
  end

  assign o_addr   = r_addr;
  assign o_last_c = i_down ? (r_addr == '0) : (r_addr == '1);
endmodule

// File: rtl/mbist_controller.sv
// March C- BIST controller: owns the memory port while testing, runs the
// six march elements, compares reads one cycle later and reports results.
// clk, rst_n : clock, async active-low reset
// bus        : start/mem_rdata in; NbarT, bist_*, done, fail, fail_addr out
module mbist_controller
  import mbist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mbist_controller_if.master  bus
);
  state_t                r_state, w_state_nxt;
  elem_idx_t             r_elem, w_elem_nxt;
  logic                  r_op, w_op_nxt;
  logic                  w_load, w_step, w_last;
  logic [ADDR_WIDTH-1:0] w_load_val, w_addr;

  march_op_t             w_op;
  logic                  w_nbart_nxt, w_we_nxt, w_re_nxt, w_done_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;

  logic                  r_nbart, r_we, r_re, r_done, r_fail;
  logic [DATA_WIDTH-1:0] r_wdata, r_cmp_exp;
  logic [ADDR_WIDTH-1:0] r_fail_addr, r_cmp_addr;
  logic                  r_cmp_vld;

  addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_step     (w_step),
    .i_down     (elem_down(r_elem)),
    .o_addr     (w_addr),
    .o_last_c   (w_last)
  );

  // State, element and op-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_elem  <= '0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Sequencing: op within address, then address, then element.
  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_op_nxt    = r_op;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_elem_nxt  = '0;
          w_op_nxt    = 1'b0;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        if (!r_op && elem_two_ops(r_elem)) begin
          w_op_nxt = 1'b1;
        end else begin
          w_op_nxt = 1'b0;
          if (!w_last) begin
            w_step = 1'b1;
          end else if (r_elem == ELEM_IW'(NUM_ELEM - 1)) begin
            w_state_nxt = FLUSH;
          end else begin
            // Wrap straight to the next element's start address.
            w_elem_nxt = r_elem + ELEM_IW'(1);
            w_load     = 1'b1;
            w_load_val = elem_down(w_elem_nxt) ? '1 : '0;
          end
        end
      end
      FLUSH:   w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next-cycle output values, decoded from the upcoming op.
  always_comb begin
    w_op        = elem_op(w_elem_nxt, w_op_nxt);
    w_nbart_nxt = (w_state_nxt == RUN) || (w_state_nxt == FLUSH);
    w_we_nxt    = (w_state_nxt == RUN) && ((w_op == W0) || (w_op == W1));
    w_re_nxt    = (w_state_nxt == RUN) && ((w_op == R0) || (w_op == R1));
    w_wdata_nxt = ((w_state_nxt == RUN) && ((w_op == W1) || (w_op == R1))) ? '1 : '0;
    w_done_nxt  = (w_state_nxt == DONE);
  end

  // Output registers, compare pipeline and sticky results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nbart     <= 1'b0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_wdata     <= '0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_exp   <= '0;
      r_cmp_addr  <= '0;
    end else begin
      r_nbart    <= w_nbart_nxt;
      r_we       <= w_we_nxt;
      r_re       <= w_re_nxt;
      r_wdata    <= w_wdata_nxt;
      r_done     <= w_done_nxt;
      // During reads the write-data bus carries the expected background.
      r_cmp_vld  <= r_re;
      r_cmp_exp  <= r_wdata;
      r_cmp_addr <= w_addr;
      if ((w_state_nxt == RUN) && (r_state != RUN)) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
      end else if (r_cmp_vld && (bus.mem_rdata != r_cmp_exp)) begin
        r_fail <= 1'b1;
        if (!r_fail) r_fail_addr <= r_cmp_addr;
      end
    end
  end

  assign bus.NbarT      = r_nbart;
  assign bus.bist_addr  = w_addr;
  assign bus.bist_wdata = r_wdata;
  assign bus.bist_we    = r_we;
  assign bus.bist_re    = r_re;
  assign bus.done       = r_done;
  assign bus.fail       = r_fail;
  assign bus.fail_addr  = r_fail_addr;
endmodule

// File: tb/tb_mbist_controller.sv
// Bench for mbist_controller: N=4 words of 8 bits behind a 1-cycle RAM with
// injectable stuck-at bits, checked against a march operation list and a
// behavioural pass/fail model.
module tb_mbist_controller;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int N  = 4;

  typedef struct {
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mbist_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  mbist_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // Stuck-at fault table applied to RAM read data.
  bit            f_en   [2];
  logic [AW-1:0] f_addr [2];
  int unsigned   f_bit  [2];
  bit            f_val  [2];

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int i = 0; i < 2; i++)
      if (f_en[i] && f_addr[i] == a) r[f_bit[i]] = f_val[i];
    return r;
  endfunction

  // Synchronous RAM behind the BIST mux leg; functional leg is idle.
  logic [DW-1:0] mem [N];
  logic [AW-1:0] ram_addr;
  assign ram_addr = bif.NbarT ? bif.bist_addr : '0;
  always @(posedge clk) begin
    if (bif.NbarT && bif.bist_we) mem[ram_addr] <= bif.bist_wdata;
    if (bif.NbarT && bif.bist_re) bif.mem_rdata <= faulty(ram_addr, mem[ram_addr]);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // March C- as a flat list of operations (code 0=w0 1=w1 2=r0 3=r1).
  op_t exp_q[$];
  task automatic build_ops();
    int e_down [6] = '{0, 0, 0, 1, 1, 1};
    int e_nops [6] = '{1, 2, 2, 2, 2, 1};
    int e_op   [6][2] = '{'{0, 0}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, 0}};
    op_t o;
    exp_q.delete();
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < N; k++)
        for (int j = 0; j < e_nops[e]; j++) begin
          o.addr = AW'(e_down[e] != 0 ? N - 1 - k : k);
          o.we   = e_op[e][j] < 2;
          o.data = (e_op[e][j] == 1 || e_op[e][j] == 3) ? '1 : '0;
          exp_q.push_back(o);
        end
  endtask

  // Replay the march against a faulty memory to get fail / first address.
  task automatic model_result(output bit fl, output logic [AW-1:0] fa);
    logic [DW-1:0] m [N];
    fl = 1'b0;
    fa = '0;
    for (int i = 0; i < N; i++) m[i] = DW'($urandom);
    foreach (exp_q[i]) begin
      if (exp_q[i].we) m[exp_q[i].addr] = exp_q[i].data;
      else if (faulty(exp_q[i].addr, m[exp_q[i].addr]) != exp_q[i].data) begin
        if (!fl) fa = exp_q[i].addr;
        fl = 1'b1;
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " NbarT"},     32'(bif.NbarT), 0);
    check({name, " we"},        32'(bif.bist_we), 0);
    check({name, " re"},        32'(bif.bist_re), 0);
    check({name, " addr"},      32'(bif.bist_addr), 0);
    check({name, " wdata"},     32'(bif.bist_wdata), 0);
    check({name, " done"},      32'(bif.done), 0);
    check({name, " fail"},      32'(bif.fail), 0);
    check({name, " fail_addr"}, 32'(bif.fail_addr), 0);
  endtask

  // One start pulse; cycle c counts from the start-sampling edge.
  task automatic run_test(input string name, input int restart_cyc, input int reset_cyc);
    bit            efl;
    logic [AW-1:0] efa;
    model_result(efl, efa);
    @(negedge clk);
    bif.start = 1'b1;
    @(posedge clk);
    #1 bif.start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      @(negedge clk);
      if (c == restart_cyc + 1) bif.start = 1'b0;
      if (c == restart_cyc) bif.start = 1'b1;
      if (c == reset_cyc) begin
        rst_n = 1'b0;
        #1 check_reset_vals($sformatf("%s async_rst c%0d", name, c));
        #1 rst_n = 1'b1;
        return;
      end
      if (c <= 40) begin
        check($sformatf("%s c%0d NbarT", name, c), 32'(bif.NbarT), 1);
        check($sformatf("%s c%0d we", name, c), 32'(bif.bist_we), 32'(exp_q[c-1].we));
        check($sformatf("%s c%0d re", name, c), 32'(bif.bist_re), 32'(!exp_q[c-1].we));
        check($sformatf("%s c%0d addr", name, c), 32'(bif.bist_addr), 32'(exp_q[c-1].addr));
        if (exp_q[c-1].we)
          check($sformatf("%s c%0d wdata", name, c), 32'(bif.bist_wdata), 32'(exp_q[c-1].data));
        if (c == 1) begin
          check($sformatf("%s c1 done", name), 32'(bif.done), 0);
          check($sformatf("%s c1 fail", name), 32'(bif.fail), 0);
          check($sformatf("%s c1 fail_addr", name), 32'(bif.fail_addr), 0);
        end
      end else if (c == 41) begin
        check($sformatf("%s flush NbarT", name), 32'(bif.NbarT), 1);
        check($sformatf("%s flush we", name), 32'(bif.bist_we), 0);
        check($sformatf("%s flush re", name), 32'(bif.bist_re), 0);
        check($sformatf("%s flush done", name), 32'(bif.done), 0);
      end else begin
        check($sformatf("%s done NbarT", name), 32'(bif.NbarT), 0);
        check($sformatf("%s done", name), 32'(bif.done), 1);
        check($sformatf("%s done we", name), 32'(bif.bist_we), 0);
        check($sformatf("%s done re", name), 32'(bif.bist_re), 0);
        check($sformatf("%s fail", name), 32'(bif.fail), 32'(efl));
        check($sformatf("%s fail_addr", name), 32'(bif.fail_addr), 32'(efa));
      end
    end
    bif.start = 1'b0;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 2; i++) begin
      f_en[i] = 1'b0; f_addr[i] = '0; f_bit[i] = 0; f_val[i] = 1'b0;
    end
  endtask

  initial begin
    bif.start = 1'b0;
    clear_faults();
    build_ops();
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fault-free run.
    run_test("clean", 0, 0);

    // Stuck-at-1 on bit 0 of word 2.
    f_en[0] = 1'b1; f_addr[0] = 2'd2; f_bit[0] = 0; f_val[0] = 1'b1;
    run_test("sa1_w2", 0, 0);
    check("sa1_w2 fail_addr_is_2", 32'(bif.fail_addr), 2);

    // Add a second fault at word 1: first failing address must stay 2.
    f_en[1] = 1'b1; f_addr[1] = 2'd1; f_bit[1] = 7; f_val[1] = 1'b0;
    run_test("two_faults", 0, 0);
    check("two_faults fail_addr_is_2", 32'(bif.fail_addr), 2);
    @(negedge clk);
    check("done_hold", 32'(bif.done), 1);
    check("fail_hold", 32'(bif.fail), 1);

    // Back-to-back from DONE with faults removed clears fail.
    clear_faults();
    run_test("b2b_clean", 0, 0);

    // Restart request mid-RUN is ignored.
    run_test("restart_ign", 10, 0);

    // Async reset mid-test, then a full run.
    run_test("rst_mid", 0, 20);
    run_test("after_rst", 0, 0);

    // Randomised stuck-at faults.
    for (int r = 0; r < 4; r++) begin
      clear_faults();
      for (int i = 0; i < 2; i++) begin
        f_en[i]   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        f_addr[i] = AW'($urandom_range(0, N - 1));
        f_bit[i]  = $urandom_range(0, DW - 1);
        f_val[i]  = 1'($urandom_range(0, 1));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_test($sformatf("rand%0d", r), 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
